// File: rtl/jts16_rowscr_fetch_pkg.sv
// jts16_rowscr_fetch_pkg: fetch FSM states and default row-scroll table addresses
package jts16_rowscr_fetch_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ1 = 2'd1,
    REQ2 = 2'd2,
    DONE = 2'd3
  } state_e;
  localparam logic [10:0] TBL1_DEF = 11'h7C0;
  localparam logic [10:0] TBL2_DEF = 11'h7E0;
  localparam logic [7:0]  TOUT_DEF = 8'd200;
  function automatic logic [15:0] hpos15(input logic [14:0] v);
    return {1'b0, v};
  endfunction
endpackage

// File: rtl/jts16_rowscr_fetch.sv
// jts16_rowscr_fetch: per-line row-scroll fetch from text RAM replacing the MMR hpos of both tile layers
module jts16_rowscr_fetch
  import jts16_rowscr_fetch_pkg::*;
#(
  parameter logic [10:0] TBL1 = TBL1_DEF,
  parameter logic [10:0] TBL2 = TBL2_DEF,
  parameter logic [7:0]  TOUT = TOUT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hs_i,
  input  logic [8:0]  vrender_i,
  input  logic        rowscr1_en_i,
  input  logic        rowscr2_en_i,
  input  logic [15:0] scr1_hpos_i,
  input  logic [15:0] scr2_hpos_i,
  output logic [10:0] ram_addr_o,
  output logic        ram_req_o,
  input  logic        ram_ack_i,
  input  logic [15:0] ram_data_i,
  output logic [15:0] hpos1_line_o,
  output logic [15:0] hpos2_line_o,
  output logic        busy_o,
  output logic        overrun_o
);
  state_e      state_q;
  logic        hs_q, slot_q, en2_q;
  logic [4:0]  row_q;
  logic [7:0]  cnt_q;
  logic [15:0] pend1_q, pend2_q;
  logic        ack, tout;
  logic [7:0]  cnt_inc;
  logic [15:0] ram_word;
  logic        unused_bits;
  assign unused_bits = &{1'b0, vrender_i[8], vrender_i[2:0], scr1_hpos_i[15], scr2_hpos_i[15], ram_data_i[15]};
  // an ack only counts while our own request is on the bus
  assign ack      = ram_ack_i & ram_req_o;
  assign cnt_inc  = cnt_q + 8'd1;
  assign tout     = ram_req_o & ~ram_ack_i & (cnt_inc == TOUT);
  assign ram_word = hpos15(ram_data_i[14:0]);
  assign busy_o   = state_q != IDLE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      hs_q         <= 1'b0;
      slot_q       <= 1'b0;
      en2_q        <= 1'b0;
      row_q        <= '0;
      cnt_q        <= '0;
      pend1_q      <= '0;
      pend2_q      <= '0;
      ram_addr_o   <= '0;
      ram_req_o    <= 1'b0;
      hpos1_line_o <= '0;
      hpos2_line_o <= '0;
      overrun_o    <= 1'b0;
    end else begin
      hs_q   <= hs_i;
      slot_q <= hs_i & ~hs_q;
      if (slot_q) begin
        hpos1_line_o <= pend1_q;
        hpos2_line_o <= pend2_q;
        pend1_q      <= hpos15(scr1_hpos_i[14:0]);
        pend2_q      <= hpos15(scr2_hpos_i[14:0]);
        row_q        <= vrender_i[7:3];
        en2_q        <= rowscr2_en_i;
        cnt_q        <= '0;
        ram_req_o    <= 1'b0;
        if (state_q != IDLE) overrun_o <= 1'b1;
        state_q <= rowscr1_en_i ? REQ1 : rowscr2_en_i ? REQ2 : DONE;
      end else begin
        case (state_q)
          REQ1, REQ2: begin
            if (ack) begin
              if (state_q == REQ1) pend1_q <= ram_word;
              else pend2_q <= ram_word;
              ram_req_o <= 1'b0;
              cnt_q     <= '0;
              state_q   <= (state_q == REQ1 && en2_q) ? REQ2 : DONE;
            end else if (tout) begin
              ram_req_o <= 1'b0;
              cnt_q     <= '0;
              overrun_o <= 1'b1;
              state_q   <= DONE;
            end else begin
              ram_req_o  <= 1'b1;
              ram_addr_o <= (state_q == REQ1 ? TBL1 : TBL2) + {6'd0, row_q};
              if (ram_req_o) cnt_q <= cnt_inc;
            end
          end
          DONE:    state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_jts16_rowscr_fetch.sv
// tb_jts16_rowscr_fetch: randomized line-by-line check of the row-scroll fetcher against a per-line outcome model
module tb_jts16_rowscr_fetch;
  localparam logic [10:0] T1 = 11'h7C0;
  localparam logic [10:0] T2 = 11'h7E0;
  localparam int TOUT = 200;
  logic        clk = 1'b0, rst = 1'b1, hs_i = 1'b0;
  logic [8:0]  vrender_i = '0;
  logic        rowscr1_en_i = 1'b0, rowscr2_en_i = 1'b0;
  logic [15:0] scr1_hpos_i = '0, scr2_hpos_i = '0;
  logic [10:0] ram_addr_o;
  logic        ram_req_o;
  logic        ram_ack_i = 1'b0;
  logic [15:0] ram_data_i = '0;
  logic [15:0] hpos1_line_o, hpos2_line_o;
  logic        busy_o, overrun_o;
  logic [15:0] mem [2048];
  logic [15:0] nx1, nx2;
  logic        exp_ov;
  int          total = 0, bad = 0;
  jts16_rowscr_fetch dut (
    .clk(clk), .rst(rst), .hs_i(hs_i), .vrender_i(vrender_i),
    .rowscr1_en_i(rowscr1_en_i), .rowscr2_en_i(rowscr2_en_i),
    .scr1_hpos_i(scr1_hpos_i), .scr2_hpos_i(scr2_hpos_i),
    .ram_addr_o(ram_addr_o), .ram_req_o(ram_req_o), .ram_ack_i(ram_ack_i),
    .ram_data_i(ram_data_i), .hpos1_line_o(hpos1_line_o), .hpos2_line_o(hpos2_line_o),
    .busy_o(busy_o), .overrun_o(overrun_o)
  );
  always #5 clk = ~clk;
  initial begin
    #5_000_000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [15:0] m15(input logic [15:0] v);
    return v & 16'h7FFF;
  endfunction
  // serve one request: d = cycles of req before ack, d>=TOUT means never ack
  task automatic serve(input logic [10:0] ea, input int d, output int gap);
    int n = 0, hi = 0;
    while (!ram_req_o && n < 20) begin @(negedge clk); n++; end
    gap = n;
    check("req_rise", ram_req_o, 1'b1);
    check("addr", ram_addr_o, ea);
    if (d < TOUT) begin
      repeat (d) @(negedge clk);
      ram_data_i = mem[ea];
      ram_ack_i  = 1'b1;
      @(negedge clk);
      ram_ack_i  = 1'b0;
      ram_data_i = $urandom;
      check("req_drop", ram_req_o, 1'b0);
    end else begin
      while (ram_req_o && hi < TOUT + 10) begin @(negedge clk); hi++; end
      check("tout_len", hi, TOUT);
    end
  endtask
  task automatic wait_idle();
    int n = 0;
    while (busy_o && n < 10) begin @(negedge clk); n++; end
    check("busy_end", busy_o, 1'b0);
    check("overrun", overrun_o, exp_ov);
    repeat (2) @(negedge clk);
  endtask
  task automatic line(input logic e1, input logic e2, input logic [15:0] h1, input logic [15:0] h2,
                      input logic [8:0] vr, input int d1, input int d2);
    logic [10:0] a1, a2;
    logic ok1, f2, ok2;
    int g;
    a1 = T1 + 11'(vr[7:3]);
    a2 = T2 + 11'(vr[7:3]);
    rowscr1_en_i = e1; rowscr2_en_i = e2; scr1_hpos_i = h1; scr2_hpos_i = h2; vrender_i = vr;
    hs_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    hs_i = 1'b0;
    check("hpos1", hpos1_line_o, nx1);
    check("hpos2", hpos2_line_o, nx2);
    check("busy_slot", busy_o, 1'b1);
    rowscr1_en_i = $urandom; rowscr2_en_i = $urandom;
    ok1 = e1 && d1 < TOUT;
    f2  = e2 && (!e1 || ok1);
    ok2 = f2 && d2 < TOUT;
    nx1 = ok1 ? m15(mem[a1]) : m15(h1);
    nx2 = ok2 ? m15(mem[a2]) : m15(h2);
    exp_ov = exp_ov | (e1 && !ok1) | (f2 && !ok2);
    if (!e1 && !e2) begin
      @(negedge clk);
      check("no_req", ram_req_o, 1'b0);
    end
    if (e1) serve(a1, d1, g);
    if (f2) begin
      serve(a2, d2, g);
      if (e1) check("gap", g, 1);
    end
    wait_idle();
  endtask
  task automatic rand_lines(input int cnt, input logic allow_tout);
    for (int i = 0; i < cnt; i++) begin
      int d1, d2;
      d1 = $urandom_range(0, 6);
      d2 = $urandom_range(0, 6);
      if (allow_tout && $urandom_range(0, 5) == 0) d1 = TOUT;
      if (allow_tout && $urandom_range(0, 5) == 0) d2 = TOUT;
      line(1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom), 9'($urandom), d1, d2);
    end
  endtask
  initial begin
    logic [10:0] ab;
    int n, g;
    for (int i = 0; i < 2048; i++) mem[i] = 16'($urandom);
    mem[11'h7C2] = 16'h80AA;
    nx1 = '0; nx2 = '0; exp_ov = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req", ram_req_o, 1'b0);
    check("rst_addr", ram_addr_o, 11'h0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_ov", overrun_o, 1'b0);
    check("rst_h1", hpos1_line_o, 16'h0);
    check("rst_h2", hpos2_line_o, 16'h0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    line(1'b0, 1'b0, 16'h0123, 16'h8456, 9'h000, 0, 0);
    line(1'b1, 1'b0, 16'h1111, 16'h2222, 9'h011, 3, 0);
    line(1'b1, 1'b1, 16'h3333, 16'h4444, 9'h0F8, 1, 2);
    rand_lines(15, 1'b0);
    // abort: second hs while REQ1 waits, with an ack landing in the slot cycle
    rowscr1_en_i = 1'b1; rowscr2_en_i = 1'b0; scr1_hpos_i = 16'hC5A5; scr2_hpos_i = 16'h0777;
    vrender_i = 9'h028; hs_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    hs_i = 1'b0;
    check("t5_h1", hpos1_line_o, nx1);
    n = 0;
    while (!ram_req_o && n < 20) begin @(negedge clk); n++; end
    check("t5_req", ram_req_o, 1'b1);
    repeat (2) @(negedge clk);
    check("t5_ov0", overrun_o, 1'b0);
    vrender_i = 9'h048; scr1_hpos_i = 16'h0ABC; scr2_hpos_i = 16'h0999; hs_i = 1'b1;
    @(negedge clk);
    ram_ack_i = 1'b1; ram_data_i = 16'h1234;
    @(negedge clk);
    ram_ack_i = 1'b0; hs_i = 1'b0;
    check("t5_drop", ram_req_o, 1'b0);
    check("t5_ov1", overrun_o, 1'b1);
    check("t5_h1c", hpos1_line_o, 16'h45A5);
    check("t5_h2c", hpos2_line_o, 16'h0777);
    @(negedge clk);
    check("t5_rereq", ram_req_o, 1'b1);
    ab = T1 + 11'd9;
    check("t5_addr", ram_addr_o, ab);
    serve(ab, 1, g);
    nx1 = m15(mem[ab]); nx2 = 16'h0999; exp_ov = 1'b1;
    wait_idle();
    line(1'b0, 1'b0, 16'h0001, 16'h0002, 9'h100, 0, 0);
    // asynchronous reset in the middle of a request
    rowscr1_en_i = 1'b1; rowscr2_en_i = 1'b1; vrender_i = 9'h0C0; hs_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    hs_i = 1'b0;
    n = 0;
    while (!ram_req_o && n < 20) begin @(negedge clk); n++; end
    check("t6_req", ram_req_o, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("t6_req0", ram_req_o, 1'b0);
    check("t6_busy0", busy_o, 1'b0);
    check("t6_ov0", overrun_o, 1'b0);
    check("t6_h1", hpos1_line_o, 16'h0);
    check("t6_h2", hpos2_line_o, 16'h0);
    @(negedge clk);
    rst = 1'b0;
    nx1 = '0; nx2 = '0; exp_ov = 1'b0;
    repeat (2) @(negedge clk);
    line(1'b0, 1'b1, 16'h0F0F, 16'hABCD, 9'h033, 0, TOUT);
    line(1'b0, 1'b0, 16'h0000, 16'h0000, 9'h000, 0, 0);
    rand_lines(15, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
